// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I controller, datapath and immediate generator.
package rv_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [SEL_W-1:0] SEXT_I = 2'd0;
  localparam logic [SEL_W-1:0] SEXT_S = 2'd1;
  localparam logic [SEL_W-1:0] SEXT_B = 2'd2;
  localparam logic [SEL_W-1:0] SEXT_U = 2'd3;

  localparam logic [SEL_W-1:0] PC_PLUS4 = 2'd0;
  localparam logic [SEL_W-1:0] PC_IMM   = 2'd1;
  localparam logic [SEL_W-1:0] PC_ALU   = 2'd2;

  localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'd2;
  localparam logic [SEL_W-1:0] WB_IMM = 2'd3;

  // True for the nine base RV32I major opcodes this controller executes.
  function automatic logic is_rv32i(input logic [OPC_W-1:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: immediate format, ALU operand selects, writeback source.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output logic [SEL_W-1:0] o_sext_op,
  output logic             o_alu_asel,
  output logic             o_alu_bsel,
  output logic [SEL_W-1:0] o_wb_sel,
  output logic             o_illegal
);

  // Opcode to static control fields; I-type/imm-operand/ALU-writeback is the common case.
  always_comb begin
    o_sext_op  = SEXT_I;
    o_alu_asel = 1'b0;
    o_alu_bsel = 1'b1;
    o_wb_sel   = WB_ALU;
    o_illegal  = !is_rv32i(i_opcode);
    case (i_opcode)
      OPC_STORE:  o_sext_op = SEXT_S;
      OPC_BRANCH: begin
        o_sext_op  = SEXT_B;
        o_alu_bsel = 1'b0;
      end
      OPC_LUI: begin
        o_sext_op = SEXT_U;
        o_wb_sel  = WB_IMM;
      end
      OPC_AUIPC: begin
        o_sext_op  = SEXT_U;
        o_alu_asel = 1'b1;
      end
      OPC_OP:            o_alu_bsel = 1'b0;
      OPC_LOAD:          o_wb_sel   = WB_MEM;
      OPC_JAL, OPC_JALR: o_wb_sel   = WB_PC4;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing and retire counter.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  inst,
  input  logic             mem_ack,
  input  logic             branch_taken,
  output logic [SEL_W-1:0] sext_op,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_fetch,
  output logic             alu_asel,
  output logic             alu_bsel,
  output logic [SEL_W-1:0] pc_sel,
  output logic [SEL_W-1:0] wb_sel,
  output logic             illegal,
  output logic [XLEN-1:0]  instret
);

  state_e           r_state;
  state_e           w_next;
  logic             r_active;
  logic [OPC_W-1:0] r_opcode;
  logic             r_illegal;
  logic [XLEN-1:0]  r_instret;

  logic [SEL_W-1:0] w_dec_sext;
  logic [SEL_W-1:0] w_dec_wb;
  logic             w_dec_asel;
  logic             w_dec_bsel;
  logic             w_dec_illegal;
  logic             w_exec_phase;
  logic             w_retire;
  logic             w_unused_inst;

  ctrl_decode u_decode (
    .i_opcode   (r_opcode),
    .o_sext_op  (w_dec_sext),
    .o_alu_asel (w_dec_asel),
    .o_alu_bsel (w_dec_bsel),
    .o_wb_sel   (w_dec_wb),
    .o_illegal  (w_dec_illegal)
  );

  // Only the major opcode field steers control.
  assign w_unused_inst = ^inst[XLEN-1:OPC_W];

  assign w_exec_phase = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);
  assign w_retire     = w_exec_phase && (w_next == ST_FETCH);

  // State, opcode latch, sticky trap flag and retire counter; r_active keeps mem_req low in the reset cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_active  <= 1'b0;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state  <= w_next;
      r_active <= 1'b1;
      if (r_state == ST_DECODE) r_opcode  <= inst[OPC_W-1:0];
      if (w_next == ST_TRAP)    r_illegal <= 1'b1;
      if (w_retire)             r_instret <= r_instret + XLEN'(1);
    end
  end

  // Next state and strobes; ack is only honoured in states that hold mem_req.
  always_comb begin
    w_next    = r_state;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_fetch = 1'b0;
    pc_sel    = PC_PLUS4;
    case (r_state)
      ST_FETCH: begin
        mem_req   = r_active;
        mem_fetch = r_active;
        if (r_active && mem_ack) begin
          ir_we  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: w_next = is_rv32i(inst[OPC_W-1:0]) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (w_dec_illegal) begin
          w_next = ST_TRAP;
        end else begin
          case (r_opcode)
            OPC_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
              w_next = ST_FETCH;
            end
            OPC_JAL, OPC_JALR: begin
              rf_we  = 1'b1;
              pc_we  = 1'b1;
              pc_sel = (r_opcode == OPC_JAL) ? PC_IMM : PC_ALU;
              w_next = ST_FETCH;
            end
            OPC_LOAD, OPC_STORE: w_next = ST_MEM;
            default:             w_next = ST_WB;
          endcase
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (r_opcode == OPC_STORE);
        if (mem_ack) begin
          if (r_opcode == OPC_STORE) begin
            pc_we  = 1'b1;
            w_next = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        w_next = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
  end

  assign sext_op  = w_dec_sext;
  assign alu_asel = w_exec_phase && w_dec_asel;
  assign alu_bsel = w_exec_phase && w_dec_bsel;
  assign wb_sel   = w_exec_phase ? w_dec_wb : WB_ALU;
  assign illegal  = r_illegal;
  assign instret  = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed protocol checks, then random instruction stream against a scoreboard.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        mem_ack;
  logic        branch_taken;
  logic [1:0]  sext_op;
  logic        ir_we, pc_we, rf_we, mem_req, mem_we, mem_fetch, alu_asel, alu_bsel;
  logic [1:0]  pc_sel, wb_sel;
  logic        illegal;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        ir;
    logic        pc;
    logic        rf;
    logic        mw;
    logic [1:0]  pcsel;
    logic [1:0]  wbsel;
    logic [1:0]  sext;
    logic        chk_sext;
    logic [31:0] instret;
  } ev_t;

  ev_t         sb_q[$];
  logic        sb_en = 1'b0;
  ev_t         mon_e;
  logic [9:0]  mon_act, mon_exp;
  logic [31:0] model_n;

  logic [6:0] opc_tab [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ack(mem_ack), .branch_taken(branch_taken),
    .sext_op(sext_op), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .mem_req(mem_req),
    .mem_we(mem_we), .mem_fetch(mem_fetch), .alu_asel(alu_asel), .alu_bsel(alu_bsel),
    .pc_sel(pc_sel), .wb_sel(wb_sel), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // One clock: change inputs just after the edge, return at the falling edge to sample.
  task automatic step(input logic ack);
    @(posedge clk); #1 mem_ack = ack;
    @(negedge clk);
  endtask

  // Directed fetch: ack after dly waiting cycles; mem_req high throughout, ir_we only on the ack cycle.
  task automatic fetch_dir(input logic [31:0] word, input int dly);
    for (int c = 0; c <= dly; c++) begin
      @(posedge clk); #1;
      mem_ack = (c == dly);
      if (c == dly) inst = word;
      @(negedge clk);
      chkb("fetch_mem_req", mem_req, 1'b1);
      chkb("fetch_mem_fetch", mem_fetch, 1'b1);
      chkb("fetch_ir_we", ir_we, c == dly);
    end
  endtask

  // Memory responder for the random phase; acks a matching request after dly cycles, random ack noise otherwise.
  task automatic mem_cycle(input logic want_fetch, input int dly);
    int  cnt = 0;
    logic ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(posedge clk); #1;
      if (mem_req && (mem_fetch == want_fetch)) begin
        mem_ack = (cnt == dly);
        ok      = (cnt == dly);
        cnt++;
      end else begin
        mem_ack = mem_req ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end
    chkb("mem_handshake_seen", ok, 1'b1);
  endtask

  // Reference: the strobe cycle that completes an instruction, from the opcode's architectural role.
  function automatic ev_t exp_done(input logic [6:0] opc, input logic taken, input logic [31:0] n);
    ev_t e;
    e = '0;
    e.pc = 1'b1;
    e.chk_sext = 1'b1;
    e.instret = n;
    case (opc)
      7'b1100011: begin e.sext = 2'd2; e.pcsel = taken ? 2'd1 : 2'd0; end
      7'b1101111: begin e.rf = 1'b1; e.wbsel = 2'd2; e.pcsel = 2'd1; end
      7'b1100111: begin e.rf = 1'b1; e.wbsel = 2'd2; e.pcsel = 2'd2; end
      7'b0100011: begin e.mw = 1'b1; e.sext = 2'd1; end
      7'b0000011: begin e.rf = 1'b1; e.wbsel = 2'd1; end
      7'b0110111: begin e.rf = 1'b1; e.wbsel = 2'd3; e.sext = 2'd3; end
      7'b0010111: begin e.rf = 1'b1; e.sext = 2'd3; end
      default:    begin e.rf = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: every strobe cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (sb_en && rst_n && (ir_we || pc_we || rf_we)) begin
      chkb("sb_event_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        mon_e   = sb_q.pop_front();
        mon_act = {ir_we, pc_we, rf_we, mem_we, pc_we ? pc_sel : 2'b0,
                   rf_we ? wb_sel : 2'b0, mon_e.chk_sext ? sext_op : 2'b0};
        mon_exp = {mon_e.ir, mon_e.pc, mon_e.rf, mon_e.mw, mon_e.pc ? mon_e.pcsel : 2'b0,
                   mon_e.rf ? mon_e.wbsel : 2'b0, mon_e.chk_sext ? mon_e.sext : 2'b0};
        chk("sb_ctrl", 32'(mon_act), 32'(mon_exp));
        chk("sb_instret", instret, mon_e.instret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  opc;
    logic [31:0] rnd;
    logic        tk;
    int          fd, md;

    rst_n = 1'b0; mem_ack = 1'b0; inst = '0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 32'({ir_we, pc_we, rf_we, mem_we, mem_req}), 32'd0);
    chk("rst_sext", 32'(sext_op), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chkb("rst_illegal", illegal, 1'b0);
    rst_n = 1'b1;

    // addi with ack after 3 idle cycles
    fetch_dir(32'h00500093, 3);
    step(1'b0);
    chkb("dec_mem_req", mem_req, 1'b0);
    chkb("dec_ir_we", ir_we, 1'b0);
    step(1'b0);
    chk("addi_ex_strobes", 32'({rf_we, pc_we, mem_req}), 32'd0);
    chkb("addi_ex_bsel", alu_bsel, 1'b1);
    chkb("addi_ex_asel", alu_asel, 1'b0);
    chk("addi_sext", 32'(sext_op), 32'd0);
    step(1'b0);
    chkb("addi_wb_rf_we", rf_we, 1'b1);
    chk("addi_wb_sel", 32'(wb_sel), 32'd0);
    chkb("addi_wb_pc_we", pc_we, 1'b1);
    chk("addi_wb_pc_sel", 32'(pc_sel), 32'd0);
    chk("addi_instret_before", instret, 32'd0);

    // beq taken then not taken
    branch_taken = 1'b1;
    fetch_dir(32'h00208463, 0);
    chk("addi_instret_after", instret, 32'd1);
    step(1'b0);
    step(1'b0);
    chkb("beq_t_pc_we", pc_we, 1'b1);
    chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq_t_sext", 32'(sext_op), 32'd2);
    chkb("beq_t_bsel", alu_bsel, 1'b0);
    chkb("beq_t_rf_we", rf_we, 1'b0);
    branch_taken = 1'b0;
    fetch_dir(32'h00208463, 0);
    chk("beq_t_instret", instret, 32'd2);
    step(1'b0);
    step(1'b0);
    chkb("beq_nt_pc_we", pc_we, 1'b1);
    chk("beq_nt_pc_sel", 32'(pc_sel), 32'd0);

    // sw with ack delayed two cycles in MEM
    fetch_dir(32'h00112223, 0);
    chk("beq_nt_instret", instret, 32'd3);
    step(1'b0);
    step(1'b0);
    chkb("sw_ex_mem_req", mem_req, 1'b0);
    chkb("sw_ex_bsel", alu_bsel, 1'b1);
    chk("sw_sext", 32'(sext_op), 32'd1);
    for (int m = 0; m < 3; m++) begin
      step(m == 2);
      chkb("sw_mem_req", mem_req, 1'b1);
      chkb("sw_mem_fetch", mem_fetch, 1'b0);
      chkb("sw_mem_we", mem_we, 1'b1);
      chkb("sw_pc_we", pc_we, m == 2);
    end
    chk("sw_pc_sel", 32'(pc_sel), 32'd0);
    step(1'b0);
    chkb("sw_back_fetch", mem_fetch, 1'b1);
    chkb("sw_mem_we_off", mem_we, 1'b0);
    chk("sw_instret", instret, 32'd4);

    // counter wrap
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    chk("wrap_preload", instret, 32'hFFFF_FFFF);
    fetch_dir(32'h00500093, 0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    fetch_dir(32'h00012083, 0);
    chk("wrap_instret", instret, 32'd0);

    // lw interrupted by reset while in MEM
    step(1'b0);
    step(1'b0);
    chkb("lw_ex_bsel", alu_bsel, 1'b1);
    step(1'b0);
    chkb("lw_mem_req", mem_req, 1'b1);
    chkb("lw_mem_we", mem_we, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chkb("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // illegal opcode traps until reset
    fetch_dir(32'h0000007F, 0);
    step(1'b0);
    chkb("ill_dec_flag", illegal, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'($urandom_range(0, 1)));
      chkb("trap_illegal", illegal, 1'b1);
      chk("trap_quiet", 32'({ir_we, pc_we, rf_we, mem_we, mem_req}), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chkb("trap_rst_illegal", illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    chkb("trap_exit_mem_req", mem_req, 1'b1);
    chkb("trap_exit_fetch", mem_fetch, 1'b1);

    // random instruction stream
    model_n = 32'd0;
    sb_en   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      opc = opc_tab[$urandom_range(0, 8)];
      tk  = 1'($urandom_range(0, 1));
      fd  = $urandom_range(0, 2);
      md  = $urandom_range(0, 3);
      mem_cycle(1'b1, fd);
      rnd = $urandom();
      inst = {rnd[31:7], opc};
      branch_taken = tk;
      sb_q.push_back('{ir: 1'b1, pc: 1'b0, rf: 1'b0, mw: 1'b0, pcsel: 2'd0, wbsel: 2'd0,
                       sext: 2'd0, chk_sext: 1'b0, instret: model_n});
      sb_q.push_back(exp_done(opc, tk, model_n));
      model_n = model_n + 32'd1;
      if (opc == 7'b0000011 || opc == 7'b0100011) mem_cycle(1'b0, md);
    end
    repeat (5) step(1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("final_instret", instret, model_n);
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
